mem_bus_arbiter: RTL and testbench

N-port round-robin arbiter merging the picorv32-style memory buses of several core_unit instances onto the single external valid/ready bus of a wavefront. It adds what the single-core path lacks: fair multi-requester sharing, registered bus outputs, per-transaction grant tracking and an optional watchdog that aborts hung transfers and raises a sticky fault.

---
 rtl/mem_bus_arb_pkg.sv | 16 +
 rtl/mem_bus_arbiter_rr.sv | 38 +++
 rtl/mem_bus_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arb_pkg.sv
// rtl/mem_bus_arb_pkg.sv - shared types and constants for the memory bus arbiter
package mem_bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam logic [3:0] WSTRB_READ = 4'b0000;
    localparam logic [3:0] WSTRB_WORD = 4'b1111;

    localparam int FAULT_BIT_TIMEOUT  = 0;
    localparam int FAULT_BIT_PROTOCOL = 1;

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// rtl/mem_bus_arbiter_rr.sv - combinational rotating-priority request encoder
//
// Module rr_arbiter: picks the first requesting port after i_last_grant,
// wrapping modulo NUM_PORTS.
//   i_req        per-port request vector
//   i_last_grant port served most recently (lowest priority this round)
//   o_grant      index of the winning port (0 when nothing requests)
//   o_any_req    at least one port is requesting
module rr_arbiter #(
    parameter  int NUM_PORTS = 4,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_last_grant,
    output logic [IDX_W-1:0]     o_grant,
    output logic                 o_any_req
);

    // Scan from the farthest port down to the nearest one so the port
    // immediately after the last grant is written last and wins.
    always_comb begin
        int idx;
        o_grant   = '0;
        o_any_req = 1'b0;
        idx       = 0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = int'(i_last_grant) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (i_req[IDX_W'(idx)]) begin
                o_grant   = IDX_W'(idx);
                o_any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin merge of per-core memory buses onto one external bus
//
// Optional watchdog: define MEM_BUS_ARB_TIMEOUT_EN to abort transfers that
// stay in BUSY for TIMEOUT_CYCLES cycles without mem_ready.
//
// Ports:
//   clk, RST            clock, synchronous active-high reset
//   core_mem_*          per-port request bundles (valid/instr/addr/wstrb/wdata)
//   core_mem_ready      one-hot, one-cycle completion pulse to the owning core
//   core_rdata          read data broadcast to all cores, valid with the pulse
//   mem_valid..data_out registered external request
//   data_in, mem_ready  external response
//   grant_id            port owning the current or last transfer
//   fault               bit0 sticky timeout, bit1 sticky protocol violation
//   fault_clr           clears the sticky fault bits
module mem_bus_arbiter
    import mem_bus_arb_pkg::*;
#(
    parameter  int          NUM_PORTS      = 4,
    parameter  int          TIMEOUT_CYCLES = 1024,
    parameter  logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
    localparam int          IDX_W          = $clog2(NUM_PORTS)
) (
    input  logic                    clk,
    input  logic                    RST,
    input  logic [NUM_PORTS-1:0]    core_mem_valid,
    input  logic [NUM_PORTS-1:0]    core_mem_instr,
    input  logic [32*NUM_PORTS-1:0] core_mem_addr,
    input  logic [4*NUM_PORTS-1:0]  core_wstrb,
    input  logic [32*NUM_PORTS-1:0] core_wdata,
    output logic [NUM_PORTS-1:0]    core_mem_ready,
    output logic [31:0]             core_rdata,
    output logic                    mem_valid,
    output logic                    mem_instr,
    output logic [31:0]             mem_addr,
    output logic [3:0]              wstrb,
    output logic [31:0]             data_out,
    input  logic [31:0]             data_in,
    input  logic                    mem_ready,
    output logic [IDX_W-1:0]        grant_id,
    output logic [7:0]              fault,
    input  logic                    fault_clr
);

    arb_state_e r_state;
    arb_state_e w_state_next;

    logic                 r_mem_valid;
    logic                 r_mem_instr;
    logic [31:0]          r_mem_addr;
    logic [3:0]           r_wstrb;
    logic [31:0]          r_data_out;
    logic [31:0]          r_core_rdata;
    logic [NUM_PORTS-1:0] r_core_mem_ready;
    logic [IDX_W-1:0]     r_grant_id;
    logic [IDX_W-1:0]     r_last_grant;
    logic                 r_fault_proto;

    logic [IDX_W-1:0]     w_grant;
    logic                 w_any_req;
    logic                 w_load;
    logic                 w_done;
    logic                 w_abort;
    logic                 w_wd_expired;
    logic                 w_proto_evt;
    logic                 w_fault_to;
    logic [NUM_PORTS-1:0] w_grant_onehot;
    logic [7:0]           w_fault;

    logic [31:0] w_addr_arr  [NUM_PORTS];
    logic [31:0] w_wdata_arr [NUM_PORTS];
    logic [3:0]  w_wstrb_arr [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign w_addr_arr[g]  = core_mem_addr[32*g +: 32];
        assign w_wdata_arr[g] = core_wdata[32*g +: 32];
        assign w_wstrb_arr[g] = core_wstrb[4*g +: 4];
    end

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr (
        .i_req        (core_mem_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_any_req    (w_any_req)
    );

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Completion beats the watchdog when both land on the same edge.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_load       = 1'b1;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    w_done       = 1'b1;
                    w_state_next = ST_RESP;
                end else if (w_wd_expired) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_grant_onehot             = '0;
        w_grant_onehot[r_grant_id] = 1'b1;
    end

    // The granted core must hold valid until it sees its ready pulse.
    assign w_proto_evt = (r_state == ST_BUSY) && !core_mem_valid[r_grant_id];

    always_ff @(posedge clk) begin
        if (RST) begin
            r_mem_valid      <= 1'b0;
            r_mem_instr      <= 1'b0;
            r_mem_addr       <= '0;
            r_wstrb          <= WSTRB_READ;
            r_data_out       <= '0;
            r_core_rdata     <= '0;
            r_core_mem_ready <= '0;
            r_grant_id       <= '0;
            r_last_grant     <= IDX_W'(NUM_PORTS - 1);
        end else begin
            r_core_mem_ready <= '0;
            if (w_load) begin
                r_mem_valid <= 1'b1;
                r_mem_instr <= core_mem_instr[w_grant];
                r_mem_addr  <= w_addr_arr[w_grant];
                r_wstrb     <= w_wstrb_arr[w_grant] & WSTRB_WORD;
                r_data_out  <= w_wdata_arr[w_grant];
                r_grant_id  <= w_grant;
            end
            if (w_done || w_abort) begin
                r_mem_valid      <= 1'b0;
                r_core_mem_ready <= w_grant_onehot;
            end
            if (w_done) begin
                r_core_rdata <= data_in;
            end else if (w_abort) begin
                r_core_rdata <= ERR_RDATA;
            end
            if (r_state == ST_RESP) begin
                r_last_grant <= r_grant_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_fault_proto <= 1'b0;
        end else if (w_proto_evt) begin
            r_fault_proto <= 1'b1;
        end else if (fault_clr) begin
            r_fault_proto <= 1'b0;
        end
    end

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_fault_to;

    // Counts completed BUSY cycles; expiry fires on the TIMEOUT_CYCLES-th one.
    always_ff @(posedge clk) begin
        if (RST || w_load) begin
            r_wd_cnt <= '0;
        end else if (r_state == ST_BUSY) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign w_wd_expired = (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (RST) begin
            r_fault_to <= 1'b0;
        end else if (w_abort) begin
            r_fault_to <= 1'b1;
        end else if (fault_clr) begin
            r_fault_to <= 1'b0;
        end
    end

    assign w_fault_to = r_fault_to;
`else
    logic w_unused_timeout;

    assign w_wd_expired     = 1'b0;
    assign w_fault_to       = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        w_fault                     = '0;
        w_fault[FAULT_BIT_TIMEOUT]  = w_fault_to;
        w_fault[FAULT_BIT_PROTOCOL] = r_fault_proto;
    end

    assign core_mem_ready = r_core_mem_ready;
    assign core_rdata     = r_core_rdata;
    assign mem_valid      = r_mem_valid;
    assign mem_instr      = r_mem_instr;
    assign mem_addr       = r_mem_addr;
    assign wstrb          = r_wstrb;
    assign data_out       = r_data_out;
    assign grant_id       = r_grant_id;
    assign fault          = w_fault;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    localparam int N   = 4;
    localparam int IW  = $clog2(N);
    localparam int TMO = 8;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
`endif

    logic            clk = 1'b0;
    logic            RST;
    logic [N-1:0]    core_mem_valid;
    logic [N-1:0]    core_mem_instr;
    logic [32*N-1:0] core_mem_addr;
    logic [4*N-1:0]  core_wstrb;
    logic [32*N-1:0] core_wdata;
    logic [N-1:0]    core_mem_ready;
    logic [31:0]     core_rdata;
    logic            mem_valid;
    logic            mem_instr;
    logic [31:0]     mem_addr;
    logic [3:0]      wstrb;
    logic [31:0]     data_out;
    logic [31:0]     data_in;
    logic            mem_ready;
    logic [IW-1:0]   grant_id;
    logic [7:0]      fault;
    logic            fault_clr;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .NUM_PORTS      (N),
        .TIMEOUT_CYCLES (TMO),
        .ERR_RDATA      (32'hDEAD_BEEF)
    ) dut (
        .clk            (clk),
        .RST            (RST),
        .core_mem_valid (core_mem_valid),
        .core_mem_instr (core_mem_instr),
        .core_mem_addr  (core_mem_addr),
        .core_wstrb     (core_wstrb),
        .core_wdata     (core_wdata),
        .core_mem_ready (core_mem_ready),
        .core_rdata     (core_rdata),
        .mem_valid      (mem_valid),
        .mem_instr      (mem_instr),
        .mem_addr       (mem_addr),
        .wstrb          (wstrb),
        .data_out       (data_out),
        .data_in        (data_in),
        .mem_ready      (mem_ready),
        .grant_id       (grant_id),
        .fault          (fault),
        .fault_clr      (fault_clr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transaction-level reference: who owns the bus, who gets the next pulse.
    int           m_owner;
    int           m_resp;
    int           m_last;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
    int           m_busy;
`endif
    logic         e_valid;
    logic         e_instr;
    logic [31:0]  e_addr;
    logic [3:0]   e_wstrb;
    logic [31:0]  e_wdata;
    logic [31:0]  e_rdata;
    logic [N-1:0] e_ready;
    int           e_gid;
    logic         e_to;
    logic         e_proto;
    logic [N-1:0] acked;

    int rr_order [5] = '{0, 1, 2, 3, 0};

    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        int p;
        for (int k = 1; k <= N; k++) begin
            p = (last + k) % N;
            if (req[p]) return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_resp  = -1;
        m_last  = N - 1;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
        m_busy  = 0;
`endif
        e_valid = 1'b0;
        e_instr = 1'b0;
        e_addr  = '0;
        e_wstrb = '0;
        e_wdata = '0;
        e_rdata = '0;
        e_ready = '0;
        e_gid   = 0;
        e_to    = 1'b0;
        e_proto = 1'b0;
        acked   = '0;
    endtask

    task automatic model_edge();
        int  prev_resp;
        int  p;
        bit  proto_evt;
        bit  to_evt;
        bit  finish;
        if (RST) begin
            model_reset();
            return;
        end
        acked     = e_ready;
        prev_resp = m_resp;
        m_resp    = -1;
        proto_evt = 1'b0;
        to_evt    = 1'b0;
        finish    = 1'b0;
        if (prev_resp >= 0) begin
            m_last = prev_resp;
        end else if (m_owner < 0) begin
            p = rr_pick(core_mem_valid, m_last);
            if (p >= 0) begin
                m_owner = p;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
                m_busy  = 0;
`endif
                e_valid = 1'b1;
                e_instr = core_mem_instr[p];
                e_addr  = core_mem_addr[32*p +: 32];
                e_wstrb = core_wstrb[4*p +: 4];
                e_wdata = core_wdata[32*p +: 32];
                e_gid   = p;
            end
        end else begin
            proto_evt = !core_mem_valid[m_owner];
`ifdef MEM_BUS_ARB_TIMEOUT_EN
            m_busy++;
`endif
            if (mem_ready) begin
                e_rdata = data_in;
                finish  = 1'b1;
            end
`ifdef MEM_BUS_ARB_TIMEOUT_EN
            else if (m_busy == TMO) begin
                e_rdata = ERR;
                to_evt  = 1'b1;
                finish  = 1'b1;
            end
`endif
            if (finish) begin
                e_valid = 1'b0;
                m_resp  = m_owner;
                m_owner = -1;
            end
        end
        e_ready = '0;
        if (m_resp >= 0) e_ready[m_resp] = 1'b1;
        e_proto = proto_evt ? 1'b1 : (fault_clr ? 1'b0 : e_proto);
        e_to    = to_evt    ? 1'b1 : (fault_clr ? 1'b0 : e_to);
    endtask

    task automatic compare_all();
        check("mem_valid",      64'(mem_valid),      64'(e_valid));
        check("mem_instr",      64'(mem_instr),      64'(e_instr));
        check("mem_addr",       64'(mem_addr),       64'(e_addr));
        check("wstrb",          64'(wstrb),          64'(e_wstrb));
        check("data_out",       64'(data_out),       64'(e_wdata));
        check("core_rdata",     64'(core_rdata),     64'(e_rdata));
        check("core_mem_ready", 64'(core_mem_ready), 64'(e_ready));
        check("grant_id",       64'(grant_id),       64'(e_gid));
        check("fault",          64'(fault),          64'({6'b0, e_proto, e_to}));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic new_req(input int p);
        int sel;
        sel = $urandom_range(0, 2);
        core_mem_valid[p]          = 1'b1;
        core_mem_instr[p]          = 1'($urandom_range(0, 1));
        core_mem_addr[32*p +: 32]  = $urandom();
        core_wdata[32*p +: 32]     = $urandom();
        core_wstrb[4*p +: 4]       = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom());
    endtask

    task automatic drive_random();
        for (int p = 0; p < N; p++) begin
            if (core_mem_valid[p] && acked[p]) begin
                if ($urandom_range(0, 1) == 0) core_mem_valid[p] = 1'b0;
                else new_req(p);
            end else if (core_mem_valid[p]) begin
                if ($urandom_range(0, 99) == 0) core_mem_valid[p] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                new_req(p);
            end
        end
        mem_ready = ($urandom_range(0, 2) == 0);
        data_in   = $urandom();
        fault_clr = ($urandom_range(0, 15) == 0);
        RST       = ($urandom_range(0, 299) == 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        RST            = 1'b1;
        core_mem_valid = '0;
        mem_ready      = 1'b0;
        fault_clr      = 1'b0;
        step();
        @(negedge clk);
        RST = 1'b0;
    endtask

    initial begin
        int np;
        RST            = 1'b1;
        core_mem_valid = '0;
        core_mem_instr = '0;
        core_mem_addr  = '0;
        core_wstrb     = '0;
        core_wdata     = '0;
        data_in        = '0;
        mem_ready      = 1'b0;
        fault_clr      = 1'b0;
        model_reset();

        // Reset state
        step();
        step();
        check("rst_valid", 64'(mem_valid), 64'd0);
        check("rst_ready", 64'(core_mem_ready), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);

        // Single read from port 0
        @(negedge clk);
        RST                  = 1'b0;
        core_mem_valid       = 4'b0001;
        core_mem_addr[31:0]  = 32'h0000_4000;
        core_wstrb[3:0]      = 4'b0000;
        step();
        check("rd_valid", 64'(mem_valid), 64'd1);
        check("rd_addr", 64'(mem_addr), 64'h4000);
        step();
        step();
        @(negedge clk);
        mem_ready = 1'b1;
        data_in   = 32'h1234_5678;
        step();
        check("rd_ready", 64'(core_mem_ready), 64'b0001);
        check("rd_rdata", 64'(core_rdata), 64'h1234_5678);
        @(negedge clk);
        mem_ready = 1'b0;
        step();
        check("rd_pulse_len", 64'(core_mem_ready), 64'd0);
        @(negedge clk);
        core_mem_valid = '0;
        step();

        // All ports requesting continuously
        do_reset();
        core_mem_valid = 4'b1111;
        mem_ready      = 1'b1;
        np             = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (core_mem_ready != '0) begin
                if (np < 5) check("rr_pulse", 64'(core_mem_ready), 64'd1 << rr_order[np]);
                np++;
            end
        end
        check("rr_count", 64'(np), 64'd5);
        @(negedge clk);
        core_mem_valid = '0;
        mem_ready      = 1'b0;
        step();

        // Write from port 2 held stable until completion
        do_reset();
        core_mem_valid         = 4'b0100;
        core_wstrb[11:8]       = 4'b1100;
        core_wdata[95:64]      = 32'hAABB_0000;
        step();
        for (int i = 0; i < 4; i++) begin
            check("wr_wstrb", 64'(wstrb), 64'hC);
            check("wr_wdata", 64'(data_out), 64'hAABB_0000);
            check("wr_gid", 64'(grant_id), 64'd2);
            step();
        end
        @(negedge clk);
        mem_ready = 1'b1;
        step();
        check("wr_ready", 64'(core_mem_ready), 64'b0100);
        @(negedge clk);
        mem_ready = 1'b0;
        step();
        @(negedge clk);
        core_mem_valid = '0;
        step();

        // Reset in the middle of a transfer
        @(negedge clk);
        core_mem_valid = 4'b1000;
        step();
        step();
        @(negedge clk);
        RST = 1'b1;
        step();
        check("midrst_valid", 64'(mem_valid), 64'd0);
        check("midrst_ready", 64'(core_mem_ready), 64'd0);
        check("midrst_gid", 64'(grant_id), 64'd0);
        @(negedge clk);
        RST            = 1'b0;
        core_mem_valid = 4'b1001;
        step();
        check("midrst_first_gid", 64'(grant_id), 64'd0);
        @(negedge clk);
        mem_ready = 1'b1;
        step();
        @(negedge clk);
        mem_ready = 1'b0;
        step();
        @(negedge clk);
        core_mem_valid = '0;
        step();

        // Granted port drops valid while its transfer is outstanding
        @(negedge clk);
        core_mem_valid = 4'b0010;
        step();
        @(negedge clk);
        core_mem_valid = '0;
        step();
        @(negedge clk);
        mem_ready = 1'b1;
        step();
        check("pf_ready", 64'(core_mem_ready), 64'b0010);
        check("pf_fault", 64'(fault), 64'h02);
        @(negedge clk);
        mem_ready = 1'b0;
        fault_clr = 1'b1;
        step();
        check("pf_clr", 64'(fault), 64'h00);
        @(negedge clk);
        fault_clr = 1'b0;
        step();

`ifdef MEM_BUS_ARB_TIMEOUT_EN
        // Watchdog abort after TMO busy cycles
        @(negedge clk);
        core_mem_valid = 4'b0001;
        step();
        for (int i = 0; i < TMO - 1; i++) step();
        check("to_still_busy", 64'(mem_valid), 64'd1);
        step();
        check("to_ready", 64'(core_mem_ready), 64'b0001);
        check("to_rdata", 64'(core_rdata), 64'hDEAD_BEEF);
        check("to_fault", 64'(fault), 64'h01);
        @(negedge clk);
        fault_clr = 1'b1;
        step();
        check("to_clr", 64'(fault), 64'h00);
        @(negedge clk);
        fault_clr      = 1'b0;
        core_mem_valid = '0;
        step();
`endif

        // Randomized traffic against the reference model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            drive_random();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
